// File: rtl/onetotwo_demux_stream.sv
// One-to-two stream demux: routes whole packets from DIN to channel A or B.
// Optional per-channel beat counters when DEMUX_BEAT_CNT_EN is defined.
//
// Ports:
//   CLK, RST_N          clock, synchronous active-low reset
//   S                   route select for the first beat of a packet (0=A, 1=B)
//   DIN, DIN_LAST       input beat data / end-of-packet marker
//   DIN_VALID/READY     input handshake (READY is combinational)
//   A_*/B_*             registered one-entry output channels with handshake
//   A_CNT/B_CNT         delivered-beat counters, saturating (macro only)
module onetotwo_demux_stream #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             S,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_LAST,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  output logic [WIDTH-1:0] A_DATA,
  output logic             A_LAST,
  output logic             A_VALID,
  input  logic             A_READY,
  output logic [WIDTH-1:0] B_DATA,
  output logic             B_LAST,
  output logic             B_VALID,
  input  logic             B_READY
`ifdef DEMUX_BEAT_CNT_EN
  ,
  output logic [15:0]      A_CNT,
  output logic [15:0]      B_CNT
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             a_valid_q, a_valid_d;
  logic             a_last_q, a_last_d;
  logic [WIDTH-1:0] a_data_q, a_data_d;
  logic             b_valid_q, b_valid_d;
  logic             b_last_q, b_last_d;
  logic [WIDTH-1:0] b_data_q, b_data_d;

  logic tgt_b;
  logic tgt_valid;
  logic tgt_ready;
  logic accept;
  logic load_a;
  logic load_b;

  // Packet lock overrides S until the last beat is accepted.
  always_comb begin
    tgt_b = S;
    unique case (state_q)
      LOCK_A:  tgt_b = 1'b0;
      LOCK_B:  tgt_b = 1'b1;
      default: tgt_b = S;
    endcase
  end

  assign tgt_valid = tgt_b ? b_valid_q : a_valid_q;
  assign tgt_ready = tgt_b ? B_READY : A_READY;

  // Only the target channel gates the input; the other may stall freely.
  assign DIN_READY = RST_N & (~tgt_valid | tgt_ready);
  assign accept    = DIN_VALID & DIN_READY;
  assign load_a    = accept & ~tgt_b;
  assign load_b    = accept & tgt_b;

  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (DIN_LAST) begin
        state_d = IDLE;
      end else if (state_q == IDLE) begin
        state_d = tgt_b ? LOCK_B : LOCK_A;
      end
    end
  end

  // Load wins over drain so a full channel can stream one beat per cycle.
  always_comb begin
    a_valid_d = a_valid_q & ~A_READY;
    a_data_d  = a_data_q;
    a_last_d  = a_last_q;
    if (load_a) begin
      a_valid_d = 1'b1;
      a_data_d  = DIN;
      a_last_d  = DIN_LAST;
    end
  end

  always_comb begin
    b_valid_d = b_valid_q & ~B_READY;
    b_data_d  = b_data_q;
    b_last_d  = b_last_q;
    if (load_b) begin
      b_valid_d = 1'b1;
      b_data_d  = DIN;
      b_last_d  = DIN_LAST;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      a_valid_q <= 1'b0;
      a_data_q  <= '0;
      a_last_q  <= 1'b0;
      b_valid_q <= 1'b0;
      b_data_q  <= '0;
      b_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_valid_q <= a_valid_d;
      a_data_q  <= a_data_d;
      a_last_q  <= a_last_d;
      b_valid_q <= b_valid_d;
      b_data_q  <= b_data_d;
      b_last_q  <= b_last_d;
    end
  end

  assign A_DATA  = a_data_q;
  assign A_LAST  = a_last_q;
  assign A_VALID = a_valid_q;
  assign B_DATA  = b_data_q;
  assign B_LAST  = b_last_q;
  assign B_VALID = b_valid_q;

`ifdef DEMUX_BEAT_CNT_EN
  logic [15:0] a_cnt_q, a_cnt_d;
  logic [15:0] b_cnt_q, b_cnt_d;

  always_comb begin
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    if (a_valid_q & A_READY & (a_cnt_q != 16'hFFFF)) begin
      a_cnt_d = a_cnt_q + 16'd1;
    end
    if (b_valid_q & B_READY & (b_cnt_q != 16'hFFFF)) begin
      b_cnt_d = b_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
    end
  end

  assign A_CNT = a_cnt_q;
  assign B_CNT = b_cnt_q;
`endif

endmodule

// File: tb/tb_onetotwo_demux_stream.sv
// Bench for onetotwo_demux_stream: packet-level model plus directed vectors.
// Define DEMUX_BEAT_CNT_EN to also exercise the beat counters.
module tb_onetotwo_demux_stream;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         S = 1'b0;
  logic [W-1:0] DIN = '0;
  logic         DIN_LAST = 1'b0;
  logic         DIN_VALID = 1'b0;
  logic         DIN_READY;
  logic [W-1:0] A_DATA;
  logic         A_LAST;
  logic         A_VALID;
  logic         A_READY = 1'b0;
  logic [W-1:0] B_DATA;
  logic         B_LAST;
  logic         B_VALID;
  logic         B_READY = 1'b0;
`ifdef DEMUX_BEAT_CNT_EN
  logic [15:0]  A_CNT;
  logic [15:0]  B_CNT;
`endif

  onetotwo_demux_stream #(.WIDTH(W)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .S(S),
    .DIN(DIN),
    .DIN_LAST(DIN_LAST),
    .DIN_VALID(DIN_VALID),
    .DIN_READY(DIN_READY),
    .A_DATA(A_DATA),
    .A_LAST(A_LAST),
    .A_VALID(A_VALID),
    .A_READY(A_READY),
    .B_DATA(B_DATA),
    .B_LAST(B_LAST),
    .B_VALID(B_VALID),
    .B_READY(B_READY)
`ifdef DEMUX_BEAT_CNT_EN
    ,
    .A_CNT(A_CNT),
    .B_CNT(B_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int nvec = 0;
  int nmis = 0;

  // Model: packet owner (-1 none, 0 A, 1 B), channel slots, counters.
  int           m_own = -1;
  bit           m_v [2];
  logic [W-1:0] m_d [2];
  bit           m_l [2];
  int           m_cnt [2];
  // Expected delivery order per channel ({last,data}) and delivered logs.
  logic [W:0]   qa [$];
  logic [W:0]   qb [$];
  logic [W-1:0] la [$];
  logic [W-1:0] lb [$];

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", n, act, exp, $time);
    end
  endtask

  function automatic int tgt();
    return (m_own < 0) ? int'(S) : m_own;
  endfunction

  function automatic bit mrdy(input int t);
    bit r;
    r = (t == 1) ? B_READY : A_READY;
    return RST_N && (!m_v[t] || r);
  endfunction

  task automatic deliver(input int c, input logic [W-1:0] d,
                         input logic l);
    if (c == 0) begin
      if (qa.size() == 0) begin
        nvec++; nmis++;
        $display("FAIL a_deliv actual=%0h required=none", d);
      end else begin
        chk("a_deliv", 32'({l, d}), 32'(qa[0]));
        void'(qa.pop_front());
      end
      la.push_back(d);
    end else begin
      if (qb.size() == 0) begin
        nvec++; nmis++;
        $display("FAIL b_deliv actual=%0h required=none", d);
      end else begin
        chk("b_deliv", 32'({l, d}), 32'(qb[0]));
        void'(qb.pop_front());
      end
      lb.push_back(d);
    end
  endtask

  // One clock: drive, check comb ready + deliveries, edge, check registers.
  task automatic step(input bit s, input bit v, input bit last,
                      input logic [W-1:0] d, input bit ar, input bit br);
    int t;
    bit acc;
    bit dr [2];
    S = s; DIN_VALID = v; DIN_LAST = last; DIN = d;
    A_READY = ar; B_READY = br;
    #1;
    t = tgt();
    acc = v && mrdy(t);
    chk("din_ready", 32'(DIN_READY), 32'(mrdy(t)));
    if (A_VALID === 1'b1 && A_READY) deliver(0, A_DATA, A_LAST);
    if (B_VALID === 1'b1 && B_READY) deliver(1, B_DATA, B_LAST);
    dr[0] = m_v[0] && ar;
    dr[1] = m_v[1] && br;
    @(posedge CLK);
    if (!RST_N) begin
      m_own = -1;
      for (int c = 0; c < 2; c++) begin
        m_v[c] = 0; m_d[c] = '0; m_l[c] = 0; m_cnt[c] = 0;
      end
      qa.delete();
      qb.delete();
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (dr[c] && m_cnt[c] < 65535) m_cnt[c]++;
        if (acc && t == c) begin
          m_v[c] = 1; m_d[c] = d; m_l[c] = last;
          if (c == 0) qa.push_back({last, d});
          else qb.push_back({last, d});
        end else if (dr[c]) begin
          m_v[c] = 0;
        end
      end
      if (acc) m_own = last ? -1 : t;
    end
    #1;
    chk("a_valid", 32'(A_VALID), 32'(m_v[0]));
    chk("a_data", 32'(A_DATA), 32'(m_d[0]));
    chk("a_last", 32'(A_LAST), 32'(m_l[0]));
    chk("b_valid", 32'(B_VALID), 32'(m_v[1]));
    chk("b_data", 32'(B_DATA), 32'(m_d[1]));
    chk("b_last", 32'(B_LAST), 32'(m_l[1]));
`ifdef DEMUX_BEAT_CNT_EN
    chk("a_cnt", 32'(A_CNT), 32'(m_cnt[0]));
    chk("b_cnt", 32'(B_CNT), 32'(m_cnt[1]));
`endif
  endtask

  initial begin
    for (int c = 0; c < 2; c++) begin
      m_v[c] = 0; m_d[c] = '0; m_l[c] = 0; m_cnt[c] = 0;
    end

    // Reset with traffic offered: ready must stay low, outputs cleared.
    RST_N = 1'b0;
    step(0, 1, 0, 8'h77, 1, 1);
    step(1, 1, 0, 8'h78, 1, 1);
    chk("rst_a_valid", 32'(A_VALID), 32'h0);
    chk("rst_b_data", 32'(B_DATA), 32'h0);
    RST_N = 1'b1;

    // Single-beat routing to A.
    step(0, 1, 1, 8'hA5, 1, 0);
    chk("sb_a_valid", 32'(A_VALID), 32'h1);
    chk("sb_a_data", 32'(A_DATA), 32'hA5);
    chk("sb_b_valid", 32'(B_VALID), 32'h0);
    step(0, 0, 0, 8'h00, 1, 1);

    // Packet lock on B ignores S until last; next packet follows S.
    la.delete(); lb.delete();
    step(1, 1, 0, 8'h01, 1, 1);
    step(0, 1, 0, 8'h02, 1, 1);
    step(0, 1, 1, 8'h03, 1, 1);
    step(0, 1, 1, 8'h44, 1, 1);
    step(0, 0, 0, 8'h00, 1, 1);
    chk("lock_b_n", 32'(lb.size()), 32'd3);
    chk("lock_b0", 32'(lb[0]), 32'h01);
    chk("lock_b1", 32'(lb[1]), 32'h02);
    chk("lock_b2", 32'(lb[2]), 32'h03);
    chk("lock_a0", 32'(la[0]), 32'h44);

    // Backpressure on A: second beat held off, no loss or duplication.
    la.delete();
    step(0, 1, 1, 8'h11, 0, 1);
    step(0, 1, 1, 8'h22, 0, 1);
    chk("bp_hold", 32'(A_DATA), 32'h11);
    step(0, 1, 1, 8'h22, 0, 1);
    chk("bp_stable", 32'(A_DATA), 32'h11);
    step(0, 1, 1, 8'h22, 1, 1);
    chk("bp_next", 32'(A_DATA), 32'h22);
    step(0, 0, 0, 8'h00, 1, 1);
    step(0, 0, 0, 8'h00, 1, 1);
    chk("bp_n", 32'(la.size()), 32'd2);
    chk("bp_a0", 32'(la[0]), 32'h11);
    chk("bp_a1", 32'(la[1]), 32'h22);

    // Stalled B does not block a stream to A.
    la.delete();
    step(1, 1, 1, 8'hBB, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 8'(8'hC0 + i), 1, 0);
      chk("ind_rdy", 32'(DIN_READY), 32'h1);
    end
    step(0, 0, 0, 8'h00, 1, 0);
    chk("ind_b_data", 32'(B_DATA), 32'hBB);
    chk("ind_n", 32'(la.size()), 32'd4);
    chk("ind_a3", 32'(la[3]), 32'hC3);
    step(0, 0, 0, 8'h00, 1, 1);

    // Reset mid-packet drops held beat and lock.
    step(0, 1, 0, 8'h55, 0, 0);
    chk("mid_a_valid", 32'(A_VALID), 32'h1);
    RST_N = 1'b0;
    step(0, 1, 0, 8'h56, 0, 0);
    chk("mid_rst_rdy", 32'(DIN_READY), 32'h0);
    chk("mid_rst_av", 32'(A_VALID), 32'h0);
    RST_N = 1'b1;
    step(1, 1, 1, 8'h66, 1, 1);
    chk("mid_b_valid", 32'(B_VALID), 32'h1);
    chk("mid_b_data", 32'(B_DATA), 32'h66);
    chk("mid_a_valid2", 32'(A_VALID), 32'h0);
    step(0, 0, 0, 8'h00, 1, 1);

    // Mixed traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0),
           8'($urandom),
           ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 1, 1);
    chk("rnd_qa_empty", 32'(qa.size()), 32'd0);
    chk("rnd_qb_empty", 32'(qb.size()), 32'd0);

`ifdef DEMUX_BEAT_CNT_EN
    // Counter saturation.
    RST_N = 1'b0;
    step(0, 0, 0, 8'h00, 1, 1);
    RST_N = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      step(0, 1, 1, 8'(i), 1, 0);
    end
    chk("sat_a_cnt", 32'(A_CNT), 32'd65535);
    chk("sat_b_cnt", 32'(B_CNT), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/onetotwo_demux_stream.md
ONETOTWO_DEMUX_STREAM -- requirements
Module: onetotwo_demux_stream

Interface
REQ-001 Parameter: WIDTH, default 8, data width of input and both output channels.
REQ-002 The block SHALL have exactly one clock; reset is synchronous and active-low.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST_N  input  1  synchronous active-low reset, sampled on rising CLK.
REQ-005 S  input  1  route select: 0 -> channel A, 1 -> channel B.
REQ-006 DIN  input  WIDTH  input beat data.
REQ-007 DIN_LAST  input  1  marks final beat of a packet.
REQ-008 DIN_VALID  input  1  input beat present.
REQ-009 DIN_READY  output  1  block accepts the beat this cycle.
REQ-010 A_DATA / B_DATA  output  WIDTH  registered channel data.
REQ-011 A_LAST / B_LAST  output  1  registered copy of DIN_LAST for the held beat.
REQ-012 A_VALID / B_VALID  output  1  channel holds a beat.
REQ-013 A_READY / B_READY  input  1  downstream accepts the held beat.

Function
REQ-014 Accept SHALL occur when DIN_VALID=1 and DIN_READY=1 on a rising CLK edge.
REQ-015 FSM states SHALL be IDLE, LOCK_A, LOCK_B; target channel = S in IDLE, A in LOCK_A, B in LOCK_B.
REQ-016 IDLE: accept with DIN_LAST=0 SHALL go to LOCK_A (S=0) or LOCK_B (S=1); accept with DIN_LAST=1 SHALL stay IDLE (single-beat packet).
REQ-017 LOCK_x: accept with DIN_LAST=1 SHALL return to IDLE; S SHALL be ignored while locked.
REQ-018 Each channel SHALL hold a one-entry output register; an accepted beat SHALL load DIN/DIN_LAST into the target channel only.
REQ-019 Latency SHALL be one cycle: beat accepted at edge N appears with x_VALID=1 after edge N.
REQ-020 DIN_READY SHALL be combinational: (~target_VALID | target_READY) while RST_N=1; 0 while RST_N=0.
REQ-021 A stalled non-target channel SHALL NOT block traffic to the target channel.
REQ-022 x_VALID SHALL clear on x_VALID & x_READY when no new beat loads that channel in the same cycle.
REQ-023 Simultaneous drain and load on one channel SHALL replace data and keep x_VALID=1 (full throughput, one beat per cycle).
REQ-024 x_DATA/x_LAST SHALL remain stable while x_VALID=1 and x_READY=0.
REQ-025 DIN_VALID=0 SHALL leave FSM and channels unchanged apart from drains.

Reset
REQ-026 While RST_N=0 at a rising edge: state IDLE, A_VALID=B_VALID=0, A_DATA=B_DATA=0, A_LAST=B_LAST=0, counters 0.
REQ-027 Reset mid-packet SHALL discard held beats and the packet lock; first post-reset accept SHALL route per S.
REQ-028 No asynchronous behaviour SHALL exist; RST_N change between edges has no effect on registers.

Configuration
REQ-029 Macro DEMUX_BEAT_CNT_EN defined: outputs A_CNT and B_CNT (16 bits each) SHALL count beats delivered (x_VALID & x_READY) per channel, saturating at 65535, reset to 0.
REQ-030 Macro DEMUX_BEAT_CNT_EN undefined: A_CNT/B_CNT ports and counter logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 Single-beat routing: S=0, DIN=8'hA5, LAST=1, VALID=1, A_READY=1 -> A_VALID=1, A_DATA=8'hA5 next cycle; B_VALID stays 0; FSM IDLE.
REQ-032 Packet lock: S=1 first beat 8'h01 LAST=0, then S=0 beats 8'h02, 8'h03 (LAST=1) -> all three on B in order; next beat with S=0 goes to A.
REQ-033 Backpressure: A_READY=0, two beats to A -> first held, DIN_READY=0 on second; A_DATA stable; A_READY=1 -> second accepted next cycle, no loss or duplication.
REQ-034 Independence: B_VALID=1 with B_READY=0, stream of 4 beats with S=0 -> all 4 delivered on A at one per cycle, B_DATA unchanged.
REQ-035 Reset mid-packet: LOCK_A with A_VALID=1, RST_N=0 for one edge -> A_VALID=0, state IDLE, DIN_READY=0 during reset; next S=1 beat lands on B.
REQ-036 With DEMUX_BEAT_CNT_EN: 70000 beats to A with A_READY=1 -> A_CNT=65535, B_CNT=0; without macro bench compiles with counter ports absent.
